// File: rtl/spi_sensor_poller.sv
// spi_sensor_poller
//
// Polls an SPI sensor on a programmable period through the shared SPI master
// FIFO interface. Each frame is NumBytes bytes, most significant byte first.
// A RawBits-wide field is taken from the frame and stored when it moved by
// more than Threshold_i, on the first sample after enable, or always when
// ReportAlways_i is set. Every store raises a one-cycle CpuIntr_o.
//
// Two cooperating FSMs:
//   sensor FSM | state         | meaning
//              | ST_DISABLED   | block off, timer held at preset
//              | ST_IDLE       | counting down to the next frame
//              | ST_XFER       | SPI frame in progress
//              | ST_EVAL       | one cycle: compare and maybe store
//   spi FSM    | SP_IDLE       | chip select high, waiting for start
//              | SP_WRITE      | push NumBytes dummy bytes into TX FIFO
//              | SP_WSTART     | wait for the master to start shifting
//              | SP_WEND       | wait for the master to finish shifting
//              | SP_READ       | pop NumBytes bytes from RX FIFO
//              | SP_DONE       | chip select high, done pulse
//
// Ports:
//   Clk_i, Reset_n_i             clock, async active-low reset
//   Enable_i, ReportAlways_i     control levels
//   CpuIntr_o                    one-cycle interrupt on store
//   Busy_o                       frame in progress
//   SensorCS_n_o                 sensor chip select (registered)
//   SPI_*                        SPI master FIFO interface and mode bits
//   PeriodCounterPreset{H,L}_i   32-bit period preset
//   Threshold_i, SensorValue_o   change threshold / last stored value

module spi_sensor_poller #(
    parameter int NumBytes  = 2,
    parameter int DataWidth = 16,
    parameter int RawShift  = 5,
    parameter int RawBits   = 11,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int LSBFE     = 0
) (
    input  logic                 Clk_i,
    input  logic                 Reset_n_i,
    input  logic                 Enable_i,
    input  logic                 ReportAlways_i,
    output logic                 CpuIntr_o,
    output logic                 Busy_o,
    output logic                 SensorCS_n_o,
    input  logic [7:0]           SPI_Data_i,
    output logic                 SPI_Write_o,
    output logic                 SPI_ReadNext_o,
    output logic [7:0]           SPI_Data_o,
    input  logic                 SPI_FIFOFull_i,
    input  logic                 SPI_FIFOEmpty_i,
    input  logic                 SPI_Transmission_i,
    input  logic [15:0]          PeriodCounterPresetH_i,
    input  logic [15:0]          PeriodCounterPresetL_i,
    input  logic [DataWidth-1:0] Threshold_i,
    output logic [DataWidth-1:0] SensorValue_o,
    output logic                 SPI_CPOL_o,
    output logic                 SPI_CPHA_o,
    output logic                 SPI_LSBFE_o
);

    localparam int FrameW = 8 * NumBytes;
    localparam int CntW   = 3;
    localparam logic [CntW-1:0] LastByte = CntW'(NumBytes - 1);
    localparam logic [DataWidth-1:0] RawMask = {DataWidth{1'b1}} >> (DataWidth - RawBits);

    typedef enum logic [1:0] {
        ST_DISABLED,
        ST_IDLE,
        ST_XFER,
        ST_EVAL
    } sens_state_e;

    typedef enum logic [2:0] {
        SP_IDLE,
        SP_WRITE,
        SP_WSTART,
        SP_WEND,
        SP_READ,
        SP_DONE
    } spi_state_e;

    sens_state_e          sens_state_q, sens_state_d;
    spi_state_e           spi_state_q, spi_state_d;
    logic [31:0]          timer_q, timer_d;
    logic                 first_q, first_d;
    logic [DataWidth-1:0] value_q, value_d;
    logic                 intr_q, intr_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [FrameW-1:0]    frame_q, frame_d;
    logic                 cs_n_q, cs_n_d;

    logic                 start;
    logic                 done;
    logic                 write;
    logic                 read;
    logic [31:0]          preset;
    logic [FrameW+DataWidth-1:0] frame_shifted;
    logic [DataWidth-1:0] raw;
    logic [DataWidth-1:0] diff;
    logic                 store;

    assign preset = {PeriodCounterPresetH_i, PeriodCounterPresetL_i};

    // Widen before shifting so the field slice is always in range, whatever
    // the relation between frame width and DataWidth.
    assign frame_shifted = {{DataWidth{1'b0}}, frame_q} >> RawShift;
    assign raw           = frame_shifted[DataWidth-1:0] & RawMask;
    assign diff          = (raw >= value_q) ? (raw - value_q) : (value_q - raw);
    assign store         = first_q | ReportAlways_i | (diff > Threshold_i);

    always_comb begin
        sens_state_d = sens_state_q;
        timer_d      = timer_q;
        first_d      = first_q;
        value_d      = value_q;
        intr_d       = 1'b0;
        start        = 1'b0;
        case (sens_state_q)
            ST_DISABLED: begin
                timer_d = preset;
                if (Enable_i) begin
                    sens_state_d = ST_IDLE;
                    first_d      = 1'b1;
                end
            end
            ST_IDLE: begin
                if (!Enable_i) begin
                    sens_state_d = ST_DISABLED;
                end else if (timer_q == 32'd0) begin
                    start        = 1'b1;
                    sens_state_d = ST_XFER;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            ST_XFER: begin
                if (done) begin
                    sens_state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (!Enable_i) begin
                    sens_state_d = ST_DISABLED;
                end else begin
                    if (store) begin
                        value_d = raw;
                        intr_d  = 1'b1;
                        first_d = 1'b0;
                    end
                    timer_d      = preset;
                    sens_state_d = ST_IDLE;
                end
            end
            default: sens_state_d = ST_DISABLED;
        endcase
    end

    always_comb begin
        spi_state_d = spi_state_q;
        cnt_d       = cnt_q;
        frame_d     = frame_q;
        write       = 1'b0;
        read        = 1'b0;
        done        = 1'b0;
        case (spi_state_q)
            SP_IDLE: begin
                if (start) begin
                    cnt_d       = '0;
                    spi_state_d = SP_WRITE;
                end
            end
            SP_WRITE: begin
                if (!SPI_FIFOFull_i) begin
                    write = 1'b1;
                    if (cnt_q == LastByte) begin
                        cnt_d       = '0;
                        spi_state_d = SP_WSTART;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            SP_WSTART: begin
                if (SPI_Transmission_i) begin
                    spi_state_d = SP_WEND;
                end
            end
            SP_WEND: begin
                if (!SPI_Transmission_i) begin
                    spi_state_d = SP_READ;
                end
            end
            SP_READ: begin
                if (!SPI_FIFOEmpty_i) begin
                    read    = 1'b1;
                    frame_d = (frame_q << 8) | FrameW'(SPI_Data_i);
                    if (cnt_q == LastByte) begin
                        cnt_d       = '0;
                        spi_state_d = SP_DONE;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            SP_DONE: begin
                done        = 1'b1;
                spi_state_d = SP_IDLE;
            end
            default: spi_state_d = SP_IDLE;
        endcase
    end

    // Chip select is registered from the next state so it cannot glitch
    // while the state vector changes between the active frame states.
    always_comb begin
        cs_n_d = 1'b1;
        if (spi_state_d == SP_WRITE || spi_state_d == SP_WSTART ||
            spi_state_d == SP_WEND  || spi_state_d == SP_READ) begin
            cs_n_d = 1'b0;
        end
    end

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            sens_state_q <= ST_DISABLED;
            spi_state_q  <= SP_IDLE;
            timer_q      <= 32'd0;
            first_q      <= 1'b1;
            value_q      <= '0;
            intr_q       <= 1'b0;
            cnt_q        <= '0;
            frame_q      <= '0;
            cs_n_q       <= 1'b1;
        end else begin
            sens_state_q <= sens_state_d;
            spi_state_q  <= spi_state_d;
            timer_q      <= timer_d;
            first_q      <= first_d;
            value_q      <= value_d;
            intr_q       <= intr_d;
            cnt_q        <= cnt_d;
            frame_q      <= frame_d;
            cs_n_q       <= cs_n_d;
        end
    end

    assign CpuIntr_o      = intr_q;
    assign Busy_o         = (spi_state_q != SP_IDLE);
    assign SensorCS_n_o   = cs_n_q;
    assign SPI_Write_o    = write;
    assign SPI_ReadNext_o = read;
    assign SPI_Data_o     = 8'h00;
    assign SensorValue_o  = value_q;
    assign SPI_CPOL_o     = 1'(CPOL);
    assign SPI_CPHA_o     = 1'(CPHA);
    assign SPI_LSBFE_o    = 1'(LSBFE);

endmodule
